// File: rtl/ifetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end: reset PC,
// buffer depth, FSM state encodings and the buffered {pc, inst} entry.
package ifetch_unit_pkg;

   localparam logic [31:0] PC_BASE_ADDR = 32'h8000_0000;
   localparam int          IFETCH_DEPTH = 2;
   localparam int          IF_STATE_W   = 1;

   localparam logic [IF_STATE_W-1:0] IF_RUN  = 1'b0;
   localparam logic [IF_STATE_W-1:0] IF_HALT = 1'b1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // PC arithmetic is modulo 2^32, so the top word wraps to address 0.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Bundles the ROM read port, the execute redirect and the decode handshake.
// valid/ready: a head entry moves to decode on a cycle where if_id_valid && id_if_ready.
interface ifetch_unit_if;
   import ifetch_unit_pkg::*;

   logic                  openmips_instrom_ren;
   logic [31:0]           openmips_instrom_addr;
   logic [31:0]           instrom_openmips_data;
   logic                  redirect_valid;
   logic [31:0]           redirect_pc;
   logic                  if_id_valid;
   logic [31:0]           if_id_pc;
   logic [31:0]           if_id_inst;
   logic                  id_if_ready;
   logic                  if_misalign;
   logic [IF_STATE_W-1:0] dbg_state;

   modport master (
      output openmips_instrom_ren, openmips_instrom_addr,
      output if_id_valid, if_id_pc, if_id_inst, if_misalign, dbg_state,
      input  instrom_openmips_data, redirect_valid, redirect_pc, id_if_ready
   );

   modport slave (
      input  openmips_instrom_ren, openmips_instrom_addr,
      input  if_id_valid, if_id_pc, if_id_inst, if_misalign, dbg_state,
      output instrom_openmips_data, redirect_valid, redirect_pc, id_if_ready
   );
endinterface

// File: rtl/ifetch_fifo.sv
// Two-entry {pc, inst} fetch buffer with same-cycle push/pop and flush.
// Entry 0 is always the head; it keeps its last value when the buffer drains.
module ifetch_fifo
   import ifetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t din_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   count_q, count_d;

   always_comb begin
      e0_d    = e0_q;
      e1_d    = e1_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (count_q == 2'd0) e0_d = din_i;
               else                 e1_d = din_i;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               // Popping the last entry leaves e0 untouched so the head holds.
               if (count_q == 2'd2) e0_d = e1_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd2) begin
                  e0_d = e1_q;
                  e1_d = din_i;
               end else begin
                  e0_d = din_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e0_q    <= '0;
         e1_q    <= '0;
         count_q <= 2'd0;
      end else begin
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         count_q <= count_d;
      end
   end

   assign head_o  = e0_q;
   assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC, ROM read port, 2-entry buffer, redirects.
// Define IFETCH_ALIGN_CHECK_EN to halt fetch on misaligned redirect targets.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int          DEPTH    = IFETCH_DEPTH,
   parameter logic [31:0] RESET_PC = PC_BASE_ADDR
) (
   input  logic          clk,
   input  logic          rst,
   ifetch_unit_if.master bus
);

   localparam logic [1:0] FULL = 2'(DEPTH);

   logic [31:0]           pc_q, pc_d;
   logic [IF_STATE_W-1:0] state_q, state_d;
   logic [31:0]           tgt;
   logic [1:0]            count;
   fetch_entry_t          head;
   logic                  ren, valid, pop;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign tgt = bus.redirect_pc;
`else
   logic [1:0] unused_tgt_low;
   assign unused_tgt_low = bus.redirect_pc[1:0];
   assign tgt            = {bus.redirect_pc[31:2], 2'b00};
`endif

   assign valid = !rst && (count != 2'd0) && !bus.redirect_valid;
   assign pop   = valid && bus.id_if_ready;
   // A full buffer still fetches when decode drains the head this cycle.
   assign ren   = !rst && (state_q == IF_RUN) && !bus.redirect_valid &&
                  ((count < FULL) || pop);

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (bus.redirect_valid) begin
         pc_d = tgt;
`ifdef IFETCH_ALIGN_CHECK_EN
         state_d = (tgt[1:0] != 2'b00) ? IF_HALT : IF_RUN;
`endif
      end else if (ren) begin
         pc_d = next_pc(pc_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= IF_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

`ifdef IFETCH_ALIGN_CHECK_EN
`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00))
         $display("PC is not 4-byte aligned");
   end
`endif
   assign bus.if_misalign = (state_q == IF_HALT);
`else
   assign bus.if_misalign = 1'b0;
`endif

   ifetch_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (ren),
      .pop_i   (pop),
      .flush_i (bus.redirect_valid),
      .din_i   ('{pc: pc_q, inst: bus.instrom_openmips_data}),
      .head_o  (head),
      .count_o (count)
   );

   assign bus.openmips_instrom_ren  = ren;
   assign bus.openmips_instrom_addr = pc_q;
   assign bus.if_id_valid           = valid;
   assign bus.if_id_pc              = head.pc;
   assign bus.if_id_inst            = head.inst;
   assign bus.dbg_state             = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: ROM model, expected-PC queue checked on every
// decode transfer, and cycle-exact checks of the ROM port and handshake.
module tb_ifetch_unit;
   import ifetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          passed = 0;
   int          total  = 0;
   int          pops   = 0;
   int          pops_mark;
   logic [31:0] exp_q[$];

   ifetch_unit_if bus ();

   ifetch_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ROM word k at 8000_0000 + 4k is 1000_0000 + k; everything else reads 0.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a < 32'h8000_1000)
         return 32'h1000_0000 + ((a - 32'h8000_0000) >> 2);
      return 32'h0;
   endfunction

   assign bus.instrom_openmips_data = rom_word(bus.openmips_instrom_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic sb_sample();
      logic [31:0] e;
      if (bus.if_id_valid === 1'b1 && bus.id_if_ready === 1'b1) begin
         pops++;
         if (exp_q.size() == 0) begin
            total++;
            $error("FAIL sb_empty: observed transfer of pc %h expected none", bus.if_id_pc);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pc", bus.if_id_pc, e);
            chk("sb_inst", bus.if_id_inst, rom_word(e));
         end
      end
   endtask

   task automatic load_stream(input logic [31:0] start, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   // Inputs change at the falling edge; checks run 1 time unit later.
   task automatic cycle(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
      @(negedge clk);
      rst                = r;
      bus.id_if_ready    = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
      sb_sample();
   endtask

   initial begin
      bus.id_if_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      load_stream(32'h8000_0000, 32);

      // Reset values
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      chk("rst_ren", 32'(bus.openmips_instrom_ren), 32'd0);
      chk("rst_addr", bus.openmips_instrom_addr, 32'h8000_0000);
      chk("rst_valid", 32'(bus.if_id_valid), 32'd0);
      chk("rst_pc", bus.if_id_pc, 32'h0);
      chk("rst_inst", bus.if_id_inst, 32'h0);
      chk("rst_misalign", 32'(bus.if_misalign), 32'd0);
      chk("rst_state", 32'(bus.dbg_state), 32'(IF_RUN));

      // First fetch, then decode sees it one cycle later
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("c1_ren", 32'(bus.openmips_instrom_ren), 32'd1);
      chk("c1_addr", bus.openmips_instrom_addr, 32'h8000_0000);
      chk("c1_valid", 32'(bus.if_id_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("c2_valid", 32'(bus.if_id_valid), 32'd1);
      chk("c2_pc", bus.if_id_pc, 32'h8000_0000);
      chk("c2_inst", bus.if_id_inst, 32'h1000_0000);
      chk("c2_addr", bus.openmips_instrom_addr, 32'h8000_0004);

      // Decode stall: buffer fills, then fetch stops
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      chk("st_ren0", 32'(bus.openmips_instrom_ren), 32'd1);
      chk("st_addr0", bus.openmips_instrom_addr, 32'h8000_0008);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      chk("st_ren", 32'(bus.openmips_instrom_ren), 32'd0);
      chk("st_addr", bus.openmips_instrom_addr, 32'h8000_000C);
      chk("st_valid", 32'(bus.if_id_valid), 32'd1);
      chk("st_pc", bus.if_id_pc, 32'h8000_0004);
      chk("st_pops", 32'(pops), 32'd1);

      // Ready while full: fetch resumes in the same cycle
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("rs_ren", 32'(bus.openmips_instrom_ren), 32'd1);
      chk("rs_addr", bus.openmips_instrom_addr, 32'h8000_000C);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("rs_pops", 32'(pops), 32'd10);
      chk("rs_pc", bus.if_id_pc, 32'h8000_0024);
      chk("rs_addr2", bus.openmips_instrom_addr, 32'h8000_002C);

      // Redirect while the buffer is full
      load_stream(32'h8000_0040, 16);
      cycle(1'b0, 1'b1, 1'b1, 32'h8000_0040);
      chk("rd_valid", 32'(bus.if_id_valid), 32'd0);
      chk("rd_ren", 32'(bus.openmips_instrom_ren), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("rd1_addr", bus.openmips_instrom_addr, 32'h8000_0040);
      chk("rd1_ren", 32'(bus.openmips_instrom_ren), 32'd1);
      chk("rd1_valid", 32'(bus.if_id_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("rd2_valid", 32'(bus.if_id_valid), 32'd1);
      chk("rd2_pc", bus.if_id_pc, 32'h8000_0040);
      chk("rd2_inst", bus.if_id_inst, 32'h1000_0010);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Misaligned redirect target
`ifdef IFETCH_ALIGN_CHECK_EN
      exp_q.delete();
      cycle(1'b0, 1'b1, 1'b1, 32'h8000_0042);
      chk("ma_valid", 32'(bus.if_id_valid), 32'd0);
      pops_mark = pops;
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("ma_misalign", 32'(bus.if_misalign), 32'd1);
      chk("ma_ren", 32'(bus.openmips_instrom_ren), 32'd0);
      chk("ma_state", 32'(bus.dbg_state), 32'(IF_HALT));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("ma_ren_hold", 32'(bus.openmips_instrom_ren), 32'd0);
      chk("ma_misalign_hold", 32'(bus.if_misalign), 32'd1);
      chk("ma_valid_hold", 32'(bus.if_id_valid), 32'd0);
      chk("ma_pops", 32'(pops), 32'(pops_mark));
      load_stream(32'h8000_0008, 16);
      cycle(1'b0, 1'b1, 1'b1, 32'h8000_0008);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("ma_clr", 32'(bus.if_misalign), 32'd0);
      chk("ma_ren_go", 32'(bus.openmips_instrom_ren), 32'd1);
      chk("ma_addr", bus.openmips_instrom_addr, 32'h8000_0008);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("ma_pc", bus.if_id_pc, 32'h8000_0008);
`else
      load_stream(32'h8000_0040, 16);
      cycle(1'b0, 1'b1, 1'b1, 32'h8000_0042);
      chk("ma_valid", 32'(bus.if_id_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("ma_misalign", 32'(bus.if_misalign), 32'd0);
      chk("ma_ren", 32'(bus.openmips_instrom_ren), 32'd1);
      chk("ma_addr", bus.openmips_instrom_addr, 32'h8000_0040);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("ma_pc", bus.if_id_pc, 32'h8000_0040);
      chk("ma_inst", bus.if_id_inst, 32'h1000_0010);
`endif
      cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Reset mid-stream with a full buffer
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      load_stream(32'h8000_0000, 16);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk("mr_valid", 32'(bus.if_id_valid), 32'd0);
      chk("mr_ren", 32'(bus.openmips_instrom_ren), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("mr1_addr", bus.openmips_instrom_addr, 32'h8000_0000);
      chk("mr1_ren", 32'(bus.openmips_instrom_ren), 32'd1);
      chk("mr1_valid", 32'(bus.if_id_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("mr2_pc", bus.if_id_pc, 32'h8000_0000);

      // PC wrap at the top of the address space
      load_stream(32'hFFFF_FFFC, 8);
      cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wr_addr0", bus.openmips_instrom_addr, 32'hFFFF_FFFC);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wr_addr1", bus.openmips_instrom_addr, 32'h0000_0000);
      chk("wr_pc0", bus.if_id_pc, 32'hFFFF_FFFC);
      chk("wr_inst0", bus.if_id_inst, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wr_pc1", bus.if_id_pc, 32'h0000_0000);
      chk("wr_addr2", bus.openmips_instrom_addr, 32'h0000_0004);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
